// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state
// encoding and the next-PC select codes reported by sel_proximo_pc.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_REG = 2'd3
  } seq_sel_t;

endpackage

// File: rtl/sequenciador_pc_if.sv
// Control-unit <-> sequencer bundle. The master side is the control unit
// (decode flags, targets, register read data); the slave side is the
// sequencer. With SEQ_IRQ_EN defined the bundle also carries irq/irq_ack/reti.
interface sequenciador_pc_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);

  logic                  start;
  logic                  stall;
  logic                  halt;
  logic                  branch;
  logic                  cond_ok;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  link;
  logic                  jalr;
  logic                  j_reg;
  logic [DATA_WIDTH-1:0] dado1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic                  link_we;
  logic                  running;
  logic                  halted;

`ifdef SEQ_IRQ_EN
  logic                  irq;
  logic                  irq_ack;
  logic                  reti;

  modport master (
    output start, stall, halt, branch, cond_ok, branch_target,
           jump, jump_addr, link, jalr, j_reg, dado1, irq, reti,
    input  pc, link_addr, link_we, running, halted, irq_ack
  );

  modport slave (
    input  start, stall, halt, branch, cond_ok, branch_target,
           jump, jump_addr, link, jalr, j_reg, dado1, irq, reti,
    output pc, link_addr, link_we, running, halted, irq_ack
  );
`else
  modport master (
    output start, stall, halt, branch, cond_ok, branch_target,
           jump, jump_addr, link, jalr, j_reg, dado1,
    input  pc, link_addr, link_we, running, halted
  );

  modport slave (
    input  start, stall, halt, branch, cond_ok, branch_target,
           jump, jump_addr, link, jalr, j_reg, dado1,
    output pc, link_addr, link_we, running, halted
  );
`endif

endinterface

// File: rtl/sequenciador_pc_sel_proximo_pc.sv
// Combinational next-PC priority selector. Register jumps (JR/JALR) win
// over immediate jumps, which win over taken branches; otherwise the PC
// advances by one and wraps at the top of the address space.
module sel_proximo_pc
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  branch,
  input  logic                  cond_ok,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  jalr,
  input  logic                  j_reg,
  input  logic [DATA_WIDTH-1:0] dado1,
  output logic [ADDR_WIDTH-1:0] pc_inc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output seq_sel_t              sel
);

  // Register bank words are wider than the address; the high bits of a
  // register jump target are simply dropped.
  logic unused_dado1_hi;
  assign unused_dado1_hi = ^dado1[DATA_WIDTH-1:ADDR_WIDTH];

  // Natural overflow of the fixed-width add gives the wrap to 0.
  assign pc_inc = pc + ADDR_WIDTH'(1);

  // Priority chain picking the fetch address for the next instruction.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_inc;
    if (jalr || j_reg) begin
      sel     = SEL_REG;
      next_pc = dado1[ADDR_WIDTH-1:0];
    end else if (jump) begin
      sel     = SEL_JMP;
      next_pc = jump_addr;
    end else if (branch && cond_ok) begin
      sel     = SEL_BR;
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/sequenciador_pc.sv
// Program-counter sequencer: owns the PC, runs the IDLE/RUN/HALT flow,
// and produces the JAL/JALR link value with a one-cycle write strobe.
// Optional feature macro: SEQ_IRQ_EN adds a single-level interrupt with
// an exception PC register, irq_ack strobe and reti return path.
module sequenciador_pc
  import seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(1)
) (
  input logic               clock,
  input logic               reset_n,
  sequenciador_pc_if.slave  bus
);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic                  advance;
  logic                  restart;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] next_pc;
  seq_sel_t              sel;
  logic [ADDR_WIDTH-1:0] link_addr_q;
  logic                  link_we_q;

  sel_proximo_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sel (
    .pc            (pc_q),
    .branch        (bus.branch),
    .cond_ok       (bus.cond_ok),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_addr     (bus.jump_addr),
    .jalr          (bus.jalr),
    .j_reg         (bus.j_reg),
    .dado1         (bus.dado1),
    .pc_inc        (pc_inc),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  // The select code is informational for the core; the PC path only needs
  // the selected address.
  logic unused_sel;
  assign unused_sel = ^sel;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the two qualifiers the datapath acts on: advance (an
  // instruction retires this cycle) and restart (start from IDLE/HALT).
  // stall beats everything, and a halt retires without redirecting the PC.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = ST_HALT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (bus.start) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SEQ_IRQ_EN
  logic [ADDR_WIDTH-1:0] epc_q;
  logic                  in_irq_q;
  logic                  irq_ack_q;
  logic                  take_irq;

  // Interrupt overlay on the selected address: reti returns to the saved
  // PC ahead of any jump; a new irq is masked while a handler is active.
  always_comb begin
    pc_d     = next_pc;
    take_irq = 1'b0;
    if (bus.reti) begin
      pc_d = epc_q;
    end else if (bus.irq && !in_irq_q) begin
      pc_d     = IRQ_VECTOR;
      take_irq = 1'b1;
    end
  end

  // Handler bookkeeping: epc keeps the address the instruction would
  // otherwise have continued at, and irq_ack pulses for one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      epc_q     <= '0;
      in_irq_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      if (advance) begin
        if (bus.reti) begin
          in_irq_q <= 1'b0;
        end else if (take_irq) begin
          epc_q     <= next_pc;
          in_irq_q  <= 1'b1;
          irq_ack_q <= 1'b1;
        end
      end
    end
  end

  assign bus.irq_ack = irq_ack_q;
`else
  logic [ADDR_WIDTH-1:0] unused_irq_vector;
  assign unused_irq_vector = IRQ_VECTOR;

  // Without interrupts the priority selector's choice is final.
  always_comb begin
    pc_d = next_pc;
  end
`endif

  // PC and link registers: restart reloads RESET_PC, a retiring
  // instruction loads the next address and optionally captures pc+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      link_addr_q <= '0;
      link_we_q   <= 1'b0;
    end else begin
      link_we_q <= 1'b0;
      if (restart) begin
        pc_q <= RESET_PC;
      end else if (advance) begin
        pc_q <= pc_d;
        if (bus.link) begin
          link_addr_q <= pc_inc;
          link_we_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.link_addr = link_addr_q;
  assign bus.link_we   = link_we_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_sequenciador_pc.sv
// Bench for sequenciador_pc: directed stimulus, a rule-level reference
// model compared on every falling edge, and literal spot checks.
module tb_sequenciador_pc;

  localparam int              AW         = 13;
  localparam int              DW         = 32;
  localparam int              PC_SPAN    = 1 << AW;
  localparam logic [AW-1:0]   RESET_PC   = 13'd0;
  localparam logic [AW-1:0]   IRQ_VECTOR = 13'd1;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  int checks = 0;
  int errors = 0;

  sequenciador_pc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sequenciador_pc #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RESET_PC),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode;
  int m_pc;
  int m_link_addr;
  int m_link_we;
  int m_in_irq;
  int m_epc;
  int m_irq_ack;

  always @(posedge clock or negedge reset_n) begin
    int tgt;
    if (!reset_n) begin
      m_mode      = 0;
      m_pc        = int'(RESET_PC);
      m_link_addr = 0;
      m_link_we   = 0;
      m_in_irq    = 0;
      m_epc       = 0;
      m_irq_ack   = 0;
    end else begin
      m_link_we = 0;
      m_irq_ack = 0;
      if (m_mode != 1) begin
        if (bus.start) begin
          m_mode = 1;
          m_pc   = int'(RESET_PC);
        end
      end else if (!bus.stall) begin
        if (bus.halt) begin
          m_mode = 2;
        end else begin
          if (bus.link) begin
            m_link_addr = (m_pc + 1) % PC_SPAN;
            m_link_we   = 1;
          end
          if (bus.jalr || bus.j_reg)       tgt = int'(bus.dado1 % PC_SPAN);
          else if (bus.jump)               tgt = int'(bus.jump_addr);
          else if (bus.branch && bus.cond_ok) tgt = int'(bus.branch_target);
          else                             tgt = (m_pc + 1) % PC_SPAN;
`ifdef SEQ_IRQ_EN
          if (bus.reti) begin
            tgt      = m_epc;
            m_in_irq = 0;
          end else if (bus.irq && m_in_irq == 0) begin
            m_epc     = tgt;
            tgt       = int'(IRQ_VECTOR);
            m_in_irq  = 1;
            m_irq_ack = 1;
          end
`endif
          m_pc = tgt;
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clock) begin
    check("pc",        32'(bus.pc),        m_pc);
    check("link_addr", 32'(bus.link_addr), m_link_addr);
    check("link_we",   32'(bus.link_we),   m_link_we);
    check("running",   32'(bus.running),   32'(m_mode == 1));
    check("halted",    32'(bus.halted),    32'(m_mode == 2));
`ifdef SEQ_IRQ_EN
    check("irq_ack",   32'(bus.irq_ack),   m_irq_ack);
`endif
  end

  task automatic idle_inputs();
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.halt          = 1'b0;
    bus.branch        = 1'b0;
    bus.cond_ok       = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_addr     = '0;
    bus.link          = 1'b0;
    bus.jalr          = 1'b0;
    bus.j_reg         = 1'b0;
    bus.dado1         = '0;
`ifdef SEQ_IRQ_EN
    bus.irq           = 1'b0;
    bus.reti          = 1'b0;
`endif
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    #1 reset_n = 1'b0;
    tick();
    tick();
    check("rst_pc",        32'(bus.pc),        32'h0);
    check("rst_running",   32'(bus.running),   32'h0);
    check("rst_halted",    32'(bus.halted),    32'h0);
    check("rst_link_we",   32'(bus.link_we),   32'h0);
    check("rst_link_addr", 32'(bus.link_addr), 32'h0);

    // Start, then sequential fetch.
    reset_n   = 1'b1;
    bus.start = 1'b1;
    tick();
    check("start_pc",      32'(bus.pc),      32'h0);
    check("start_running", 32'(bus.running), 32'h1);
    bus.start = 1'b0;
    tick(); check("seq_pc1", 32'(bus.pc), 32'd1);
    tick(); check("seq_pc2", 32'(bus.pc), 32'd2);
    tick(); check("seq_pc3", 32'(bus.pc), 32'd3);
    tick();
    tick(); check("seq_pc5", 32'(bus.pc), 32'd5);

    // JALR with link, upper dado1 bits dropped.
    bus.jalr  = 1'b1;
    bus.link  = 1'b1;
    bus.dado1 = 32'hFFFF_0123;
    tick();
    check("jalr_pc",        32'(bus.pc),        32'h0123);
    check("jalr_link_addr", 32'(bus.link_addr), 32'd6);
    check("jalr_link_we",   32'(bus.link_we),   32'd1);
    idle_inputs();
    tick();
    check("jalr_we_drop", 32'(bus.link_we), 32'd0);
    check("jalr_seq",     32'(bus.pc),      32'h0124);

    // Priority: register jump over immediate jump over branch.
    bus.j_reg         = 1'b1;
    bus.jump          = 1'b1;
    bus.branch        = 1'b1;
    bus.cond_ok       = 1'b1;
    bus.dado1         = 32'h0000_0777;
    bus.jump_addr     = 13'h0400;
    bus.branch_target = 13'h0200;
    tick(); check("prio_reg", 32'(bus.pc), 32'h0777);
    bus.j_reg = 1'b0;
    tick(); check("prio_jmp", 32'(bus.pc), 32'h0400);
    bus.jump    = 1'b0;
    bus.cond_ok = 1'b0;
    tick(); check("prio_notaken", 32'(bus.pc), 32'h0401);
    bus.cond_ok = 1'b1;
    tick(); check("prio_br", 32'(bus.pc), 32'h0200);
    idle_inputs();

    // Wrap at the top address.
    bus.jump      = 1'b1;
    bus.jump_addr = 13'h1FFF;
    tick(); check("wrap_top", 32'(bus.pc), 32'h1FFF);
    bus.jump = 1'b0;
    bus.link = 1'b1;
    tick();
    check("wrap_zero",      32'(bus.pc),        32'h0);
    check("wrap_link_addr", 32'(bus.link_addr), 32'h0);
    bus.link = 1'b0;

    // Stall holds everything and suppresses the link strobe.
    tick();
    bus.stall     = 1'b1;
    bus.jump      = 1'b1;
    bus.jump_addr = 13'h0055;
    bus.link      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(bus.pc),      32'd1);
      check("stall_we", 32'(bus.link_we), 32'd0);
    end
    idle_inputs();
    tick(); check("stall_release", 32'(bus.pc), 32'd2);

    // Halt with a simultaneous jump, then restart.
    bus.jump      = 1'b1;
    bus.jump_addr = 13'd9;
    tick(); check("halt_setup", 32'(bus.pc), 32'd9);
    bus.halt      = 1'b1;
    bus.jump_addr = 13'h0033;
    tick();
    check("halt_halted",  32'(bus.halted),  32'd1);
    check("halt_running", 32'(bus.running), 32'd0);
    check("halt_pc",      32'(bus.pc),      32'd9);
    idle_inputs();
    bus.jump      = 1'b1;
    bus.jump_addr = 13'h0044;
    tick(); check("halt_hold", 32'(bus.pc), 32'd9);
    idle_inputs();
    bus.start = 1'b1;
    tick();
    check("restart_pc",  32'(bus.pc),      32'(RESET_PC));
    check("restart_run", 32'(bus.running), 32'd1);
    tick(); check("start_in_run", 32'(bus.pc), 32'd1);
    bus.start = 1'b0;
    tick(); check("after_start", 32'(bus.pc), 32'd2);

    // Asynchronous reset mid-instruction: no link write.
    bus.jalr  = 1'b1;
    bus.link  = 1'b1;
    bus.dado1 = 32'h0000_0099;
    #2 reset_n = 1'b0;
    tick();
    check("areset_pc",  32'(bus.pc),      32'd0);
    check("areset_we",  32'(bus.link_we), 32'd0);
    check("areset_run", 32'(bus.running), 32'd0);
    reset_n = 1'b1;
    idle_inputs();
    tick(); check("areset_idle", 32'(bus.running), 32'd0);

`ifdef SEQ_IRQ_EN
    // Interrupt entry, masked nesting, return.
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.jump      = 1'b1;
    bus.jump_addr = 13'd20;
    tick(); check("irq_setup", 32'(bus.pc), 32'd20);
    idle_inputs();
    bus.irq = 1'b1;
    tick();
    check("irq_vec", 32'(bus.pc),      32'(IRQ_VECTOR));
    check("irq_ack", 32'(bus.irq_ack), 32'd1);
    tick();
    check("irq_masked",  32'(bus.pc),      32'(IRQ_VECTOR) + 32'd1);
    check("irq_ack_low", 32'(bus.irq_ack), 32'd0);
    bus.irq  = 1'b0;
    bus.reti = 1'b1;
    tick(); check("reti_pc", 32'(bus.pc), 32'd21);
    idle_inputs();
    tick(); check("reti_seq", 32'(bus.pc), 32'd22);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
